// File: rtl/fetch_pc_unit.sv
// Instruction fetch sequencer with program counter and optional return-address stack.
// Define FETCH_RAS_EN to build the return-address stack; without it ret is ignored.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int          RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] program_counter,
    input  logic [31:0] program_counter_next,
    input  logic [31:0] next_r14,
    input  logic [10:0] ALUCtl_code,
    input  logic        ret,
    input  logic        exec_done,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [4:0]  ras_count,
    output logic        ras_overflow,
    output logic        ras_underflow
);

    localparam logic [10:0] ALU_BRANCH_LINK = 11'd32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] instr_reg;
    logic        imem_req_reg;
    logic        instr_valid_reg;
    logic [31:0] pc_sel;
    logic        issue_fire;

    assign issue_fire = (state_reg == ISSUE) && exec_done;

`ifdef FETCH_RAS_EN
    localparam int          PTR_W       = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [4:0]  DEPTH_COUNT = 5'(RAS_DEPTH);

    logic [31:0]      ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] top_reg;
    logic [PTR_W-1:0] write_idx;
    logic [4:0]       count_reg;
    logic             overflow_reg;
    logic             underflow_reg;
    logic             ras_empty;
    logic             do_pop;
    logic             do_push;

    assign ras_empty = (count_reg == 5'd0);
    assign do_pop    = issue_fire && ret && !ras_empty;
    assign do_push   = issue_fire && (ALUCtl_code == ALU_BRANCH_LINK);
    // Pop-then-push rewrites the current top; a plain push advances first,
    // so a full stack naturally overwrites its oldest slot.
    assign write_idx = do_pop ? top_reg : top_reg + 1'b1;
    assign pc_sel    = do_pop ? ras_mem[top_reg] : program_counter_next;

    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            ras_mem[write_idx] <= next_r14;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            top_reg       <= '0;
            count_reg     <= 5'd0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (issue_fire) begin
            if (ret && ras_empty) begin
                underflow_reg <= 1'b1;
            end
            case ({do_pop, do_push})
                2'b10: begin
                    top_reg   <= top_reg - 1'b1;
                    count_reg <= count_reg - 5'd1;
                end
                2'b01: begin
                    top_reg <= top_reg + 1'b1;
                    if (count_reg == DEPTH_COUNT) begin
                        overflow_reg <= 1'b1;
                    end else begin
                        count_reg <= count_reg + 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ras_count     = count_reg;
    assign ras_overflow  = overflow_reg;
    assign ras_underflow = underflow_reg;
`else
    logic [4:0] unused_depth;
    logic       unused_ras_inputs;

    assign unused_depth      = 5'(RAS_DEPTH);
    assign unused_ras_inputs = ^{ret, next_r14, ALUCtl_code, unused_depth, issue_fire};
    assign pc_sel            = program_counter_next;
    assign ras_count         = 5'd0;
    assign ras_overflow      = 1'b0;
    assign ras_underflow     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            pc_reg          <= RESET_PC;
            instr_reg       <= 32'd0;
            imem_req_reg    <= 1'b0;
            instr_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg    <= FETCH;
                    imem_req_reg <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr_reg       <= imem_data;
                        state_reg       <= ISSUE;
                        imem_req_reg    <= 1'b0;
                        instr_valid_reg <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (exec_done) begin
                        pc_reg          <= pc_sel;
                        state_reg       <= FETCH;
                        imem_req_reg    <= 1'b1;
                        instr_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg       <= IDLE;
                    imem_req_reg    <= 1'b0;
                    instr_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req        = imem_req_reg;
    assign imem_addr       = pc_reg;
    assign program_counter = pc_reg;
    assign instr           = instr_reg;
    assign instr_valid     = instr_valid_reg;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a transaction-level model checked every cycle.
// Adapts its expectations to whether FETCH_RAS_EN is defined.
module tb_fetch_pc_unit;

`ifdef FETCH_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = 32'd0;
    logic [31:0] program_counter;
    logic [31:0] program_counter_next = 32'd0;
    logic [31:0] next_r14 = 32'd0;
    logic [10:0] ALUCtl_code = 11'd0;
    logic        ret = 1'b0;
    logic        exec_done = 1'b0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [4:0]  ras_count;
    logic        ras_overflow;
    logic        ras_underflow;

    fetch_pc_unit #(.RESET_PC(32'd0), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .program_counter(program_counter),
        .program_counter_next(program_counter_next),
        .next_r14(next_r14), .ALUCtl_code(ALUCtl_code),
        .ret(ret), .exec_done(exec_done),
        .instr(instr), .instr_valid(instr_valid),
        .ras_count(ras_count), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
    endtask

    // Model: phase 0 = waiting one cycle after reset, 1 = fetching, 2 = holding an instruction.
    int          m_phase = 0;
    logic [31:0] m_pc = 32'd0;
    logic [31:0] m_instr = 32'd0;
    logic [31:0] m_stack[$];
    bit          m_ovf = 0, m_udf = 0;
    bit          model_live = 0;
    bit          done = 0;

    always @(posedge clk) begin
        logic [31:0] target;
        model_live = 1;
        if (reset) begin
            m_phase = 0; m_pc = 32'd0; m_instr = 32'd0;
            m_stack.delete(); m_ovf = 0; m_udf = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (imem_ack) begin m_instr = imem_data; m_phase = 2; end
        end else if (exec_done) begin
            target = program_counter_next;
            if (RAS_ON) begin
                if (ret) begin
                    if (m_stack.size() > 0) target = m_stack.pop_back();
                    else m_udf = 1;
                end
                if (ALUCtl_code == 11'd32) begin
                    if (m_stack.size() == DEPTH) begin
                        void'(m_stack.pop_front());
                        m_ovf = 1;
                    end
                    m_stack.push_back(next_r14);
                end
            end
            m_pc = target;
            m_phase = 1;
        end
    end

    always @(negedge clk) begin
        if (model_live && !done) begin
            check("imem_req", {31'd0, imem_req}, {31'd0, m_phase == 1});
            check("instr_valid", {31'd0, instr_valid}, {31'd0, m_phase == 2});
            check("imem_addr", imem_addr, m_pc);
            check("program_counter", program_counter, m_pc);
            check("instr", instr, m_instr);
            check("ras_count", {27'd0, ras_count}, RAS_ON ? m_stack.size() : 0);
            check("ras_overflow", {31'd0, ras_overflow}, {31'd0, RAS_ON && m_ovf});
            check("ras_underflow", {31'd0, ras_underflow}, {31'd0, RAS_ON && m_udf});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 20) begin step(); n++; end
        if (!imem_req) check("req_timeout", {31'd0, imem_req}, 32'd1);
    endtask

    // One instruction: fetch at exp_addr after `waits` stalled cycles, then execute.
    task automatic do_instr(input logic [31:0] exp_addr, input logic [31:0] nxt,
                            input logic [31:0] r14, input logic [10:0] alu,
                            input logic r, input int waits);
        wait_req();
        check("fetch_addr", imem_addr, exp_addr);
        for (int i = 0; i < waits; i++) begin
            exec_done = 1'b1;
            ret = 1'b1;
            program_counter_next = 32'hDEAD_0000;
            step();
        end
        exec_done = 1'b0;
        ret = 1'b0;
        if (waits > 0) check("stall_addr", imem_addr, exp_addr);
        imem_ack = 1'b1;
        imem_data = exp_addr ^ 32'hA5A5_0000;
        step();
        imem_ack = 1'b0;
        program_counter_next = nxt;
        next_r14 = r14;
        ALUCtl_code = alu;
        ret = r;
        exec_done = 1'b1;
        step();
        exec_done = 1'b0;
        ret = 1'b0;
        ALUCtl_code = 11'd0;
        $display("instr pc=%0d next=%0d r14=%0d alu=%0d ret=%0d -> pc=%0d ras_count=%0d",
                 exp_addr, nxt, r14, alu, r, program_counter, ras_count);
    endtask

    initial begin
        repeat (3) step();
        check("reset_pc", program_counter, 32'd0);
        check("reset_req", {31'd0, imem_req}, 32'd0);
        check("reset_valid", {31'd0, instr_valid}, 32'd0);
        check("reset_count", {27'd0, ras_count}, 32'd0);
        reset = 1'b0;
        #1;
        check("idle_req", {31'd0, imem_req}, 32'd0);
        step();
        check("fetch_after_idle", {31'd0, imem_req}, 32'd1);

        // Sequential fetch
        do_instr(32'd0, 32'd1, 32'd0, 11'd0, 1'b0, 0);
        do_instr(32'd1, 32'd2, 32'd0, 11'd0, 1'b0, 0);
        do_instr(32'd2, 32'd3, 32'd0, 11'd0, 1'b0, 0);
        do_instr(32'd3, 32'd234, 32'd0, 11'd0, 1'b0, 0);

        // Branch
        do_instr(32'd234, 32'd734, 32'd0, 11'd31, 1'b0, 0);
        check("branch_count", {27'd0, ras_count}, 32'd0);

        // BranchLink then return
        do_instr(32'd734, 32'd675, 32'd0, 11'd0, 1'b0, 0);
        do_instr(32'd675, 32'd1275, 32'd676, 11'd32, 1'b0, 0);
        check("bl_count", {27'd0, ras_count}, RAS_ON ? 32'd1 : 32'd0);
        do_instr(32'd1275, 32'd1280, 32'd0, 11'd0, 1'b0, 0);
        do_instr(32'd1280, 32'd9999, 32'd0, 11'd0, 1'b1, 0);
        check("ret_pc", program_counter, RAS_ON ? 32'd676 : 32'd9999);
        check("ret_count", {27'd0, ras_count}, 32'd0);

        // Five pushes into a four-deep stack, then drain past empty
        do_instr(RAS_ON ? 32'd676 : 32'd9999, 32'd100, 32'd10, 11'd32, 1'b0, 0);
        do_instr(32'd100, 32'd101, 32'd11, 11'd32, 1'b0, 0);
        do_instr(32'd101, 32'd102, 32'd12, 11'd32, 1'b0, 0);
        do_instr(32'd102, 32'd103, 32'd13, 11'd32, 1'b0, 0);
        do_instr(32'd103, 32'd104, 32'd14, 11'd32, 1'b0, 0);
        check("full_count", {27'd0, ras_count}, RAS_ON ? 32'd4 : 32'd0);
        check("overflow", {31'd0, ras_overflow}, {31'd0, RAS_ON});
        do_instr(32'd104, 32'd200, 32'd0, 11'd0, 1'b1, 0);
        check("pop14", program_counter, RAS_ON ? 32'd14 : 32'd200);
        do_instr(program_counter, 32'd300, 32'd0, 11'd0, 1'b1, 0);
        check("pop13", program_counter, RAS_ON ? 32'd13 : 32'd300);
        do_instr(program_counter, 32'd400, 32'd0, 11'd0, 1'b1, 0);
        check("pop12", program_counter, RAS_ON ? 32'd12 : 32'd400);
        do_instr(program_counter, 32'd450, 32'd0, 11'd0, 1'b1, 0);
        check("pop11", program_counter, RAS_ON ? 32'd11 : 32'd450);
        check("underflow_before", {31'd0, ras_underflow}, 32'd0);
        do_instr(program_counter, 32'd500, 32'd0, 11'd0, 1'b1, 0);
        check("empty_ret_pc", program_counter, 32'd500);
        check("underflow", {31'd0, ras_underflow}, {31'd0, RAS_ON});

        // Simultaneous return and push replaces the top
        do_instr(32'd500, 32'd600, 32'd77, 11'd32, 1'b0, 0);
        do_instr(32'd600, 32'd610, 32'd88, 11'd32, 1'b0, 0);
        do_instr(32'd610, 32'd620, 32'd99, 11'd32, 1'b1, 0);
        check("swap_pc", program_counter, RAS_ON ? 32'd88 : 32'd620);
        check("swap_count", {27'd0, ras_count}, RAS_ON ? 32'd2 : 32'd0);
        do_instr(program_counter, 32'd630, 32'd0, 11'd0, 1'b1, 0);
        check("swap_top", program_counter, RAS_ON ? 32'd99 : 32'd630);
        do_instr(program_counter, 32'd640, 32'd0, 11'd0, 1'b1, 0);
        check("swap_bottom", program_counter, RAS_ON ? 32'd77 : 32'd640);

        // PC wraps at 2^32, then a stalled fetch with stray exec_done
        do_instr(program_counter, 32'hFFFF_FFFF, 32'd0, 11'd0, 1'b0, 0);
        do_instr(32'hFFFF_FFFF, 32'd0, 32'd0, 11'd0, 1'b0, 0);
        do_instr(32'd0, 32'd42, 32'd0, 11'd0, 1'b0, 3);
        check("after_stall_pc", program_counter, 32'd42);

        // Ack while holding an instruction is ignored
        wait_req();
        imem_ack = 1'b1; imem_data = 32'h1111_2222;
        step();
        imem_data = 32'h3333_4444;
        step();
        check("issue_ack_ignored", instr, 32'h1111_2222);
        imem_ack = 1'b0;

        // Reset while holding an instruction, with ack and exec_done raised
        reset = 1'b1; imem_ack = 1'b1; exec_done = 1'b1;
        program_counter_next = 32'd777;
        step();
        check("rst_issue_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_issue_pc", program_counter, 32'd0);
        check("rst_issue_instr", instr, 32'd0);
        reset = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
        $display("reset in issue -> pc=%0d instr_valid=%0d", program_counter, instr_valid);
        do_instr(32'd0, 32'd5, 32'd0, 11'd0, 1'b0, 1);

        // Reset during a fetch that is acked in the reset cycle
        wait_req();
        reset = 1'b1; imem_ack = 1'b1; imem_data = 32'hBEEF_0001;
        step();
        reset = 1'b0; imem_ack = 1'b0;
        check("rst_fetch_instr", instr, 32'd0);
        do_instr(32'd0, 32'd1, 32'd0, 11'd0, 1'b0, 0);

        step();
        done = 1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
